param_muldiv_alu: RTL and testbench

Parametrised next-generation datapath ALU for the midterm CPU core. Generalises the 32-bit TotalALU operation set to any `WIDTH` and adds a sequential unsigned divider alongside the sequential multiplier. Adds an explicit `busy`/`done` handshake and edge-triggered start, so a held opcode never restarts a long operation. Sits between the register file read ports and the write-back mux; results of MULTU/DIVU land in an internal Hi-Lo pair read back with MFHI/MFLO.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/muldiv_seq_unit.sv | 131 +++++++++++++
 rtl/param_muldiv_alu.sv | 98 +++++++++
 tb/tb_param_muldiv_alu.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for param_muldiv_alu and its sequential multiply/divide
// unit: function codes carried on Signal, the sequencer state encoding, and
// the helper that sizes the step counter.
// -----------------------------------------------------------------------------
package alu_pkg;

   localparam logic [5:0] FN_AND   = 6'd36;
   localparam logic [5:0] FN_OR    = 6'd37;
   localparam logic [5:0] FN_ADD   = 6'd32;
   localparam logic [5:0] FN_SUB   = 6'd34;
   localparam logic [5:0] FN_SLT   = 6'd42;
   localparam logic [5:0] FN_SRL   = 6'd2;
   localparam logic [5:0] FN_MULTU = 6'd25;
   localparam logic [5:0] FN_DIVU  = 6'd27;
   localparam logic [5:0] FN_MFHI  = 6'd16;
   localparam logic [5:0] FN_MFLO  = 6'd18;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN_MUL = 2'd1,
      RUN_DIV = 2'd2
   } seq_state_t;

   // The counter must be able to hold the value WIDTH itself.
   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/muldiv_seq_unit.sv
// -----------------------------------------------------------------------------
// muldiv_seq_unit
// Sequential unsigned multiplier (shift-add) and restoring divider sharing one
// 2*WIDTH accumulator. Each operation takes WIDTH steps; the result lands in
// the Hi/Lo pair on the same edge that done pulses.
//
// Ports:
//   i_clk        rising-edge clock
//   i_reset      synchronous active-high reset, aborts any running operation
//   i_start_mul  opcode-entry strobe for MULTU (ignored unless idle)
//   i_start_div  opcode-entry strobe for DIVU  (ignored unless idle)
//   i_opa        multiplicand / dividend
//   i_opb        multiplier / divisor
//   o_hi, o_lo   product upper/lower half, or remainder/quotient
//   o_busy       high while an operation runs
//   o_done       one-cycle pulse on the edge Hi/Lo is written
//   o_dz         sticky divide-by-zero flag of the last DIVU
// -----------------------------------------------------------------------------
module muldiv_seq_unit
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start_mul,
   input  logic             i_start_div,
   input  logic [WIDTH-1:0] i_opa,
   input  logic [WIDTH-1:0] i_opb,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_dz
);

   localparam int            CW   = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   seq_state_t         r_state;
   logic [CW-1:0]      r_cnt;
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_opnd;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic               r_busy;
   logic               r_done;
   logic               r_dz;

   logic [WIDTH:0]     w_mul_sum;
   logic [2*WIDTH-1:0] w_acc_mul;
   logic [WIDTH:0]     w_div_trial;
   logic [WIDTH-1:0]   w_div_diff;
   logic [2*WIDTH-1:0] w_acc_div;
   logic [2*WIDTH-1:0] w_acc_next;

   // Multiply step: acc = {partial product, remaining multiplier bits}.
   // Divide step:   acc = {partial remainder, remaining dividend / quotient}.
   // With a zero divisor every trial subtract succeeds, so the quotient fills
   // with ones and the dividend shifts through unchanged into the remainder.
   always_comb begin
      w_mul_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
      w_acc_mul   = {w_mul_sum, r_acc[WIDTH-1:1]};
      w_div_trial = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
      w_div_diff  = w_div_trial[WIDTH-1:0] - r_opnd;
      if (w_div_trial >= {1'b0, r_opnd})
         w_acc_div = {w_div_diff, r_acc[WIDTH-2:0], 1'b1};
      else
         w_acc_div = {w_div_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
      w_acc_next  = (r_state == RUN_DIV) ? w_acc_div : w_acc_mul;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_acc   <= '0;
         r_opnd  <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_dz    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (i_start_mul) begin
                  r_state <= RUN_MUL;
                  r_busy  <= 1'b1;
                  r_cnt   <= '0;
                  r_acc   <= {{WIDTH{1'b0}}, i_opb};
                  r_opnd  <= i_opa;
               end else if (i_start_div) begin
                  r_state <= RUN_DIV;
                  r_busy  <= 1'b1;
                  r_cnt   <= '0;
                  r_acc   <= {{WIDTH{1'b0}}, i_opa};
                  r_opnd  <= i_opb;
                  r_dz    <= 1'b0;
               end
            end
            RUN_MUL, RUN_DIV: begin
               r_acc <= w_acc_next;
               r_cnt <= r_cnt + CW'(1);
               // Final step: the result is written straight from the step logic.
               if (r_cnt == LAST) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_hi    <= w_acc_next[2*WIDTH-1:WIDTH];
                  r_lo    <= w_acc_next[WIDTH-1:0];
                  if (r_state == RUN_DIV)
                     r_dz <= (r_opnd == '0);
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign o_hi   = r_hi;
   assign o_lo   = r_lo;
   assign o_busy = r_busy;
   assign o_done = r_done;
   assign o_dz   = r_dz;

endmodule

// File: rtl/param_muldiv_alu.sv
// -----------------------------------------------------------------------------
// param_muldiv_alu
// WIDTH-bit ALU: single-cycle AND/OR/ADD/SUB/SLT/SRL/MFHI/MFLO with a
// registered result, plus MULTU/DIVU run by muldiv_seq_unit into Hi/Lo.
// MULTU/DIVU start only on opcode entry, so a held code never restarts.
//
// Ports:
//   clk     rising-edge clock
//   reset   synchronous active-high reset
//   dataA   operand A (dividend / multiplicand / shift source)
//   dataB   operand B (divisor / multiplier / shift amount in [SHW-1:0])
//   Signal  6-bit function code
//   Output  registered result; holds for unknown codes and MULTU/DIVU
//   busy    high while MULTU/DIVU runs
//   done    one-cycle pulse when Hi/Lo is written
//   dz      sticky divide-by-zero flag of the last DIVU
// -----------------------------------------------------------------------------
module param_muldiv_alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] dataA,
   input  logic [WIDTH-1:0] dataB,
   input  logic [5:0]       Signal,
   output logic [WIDTH-1:0] Output,
   output logic             busy,
   output logic             done,
   output logic             dz
);

   logic [5:0]              r_prev_sig;
   logic [WIDTH-1:0]        r_out;

   logic                    w_start_mul;
   logic                    w_start_div;
   logic [WIDTH-1:0]        w_hi;
   logic [WIDTH-1:0]        w_lo;
   logic signed [WIDTH-1:0] w_sa;
   logic signed [WIDTH-1:0] w_sb;
   logic                    w_slt;
   logic [WIDTH-1:0]        w_out_next;

   // Opcode entry: code present now but not in the previous cycle.
   assign w_start_mul = (Signal == FN_MULTU) && (r_prev_sig != FN_MULTU);
   assign w_start_div = (Signal == FN_DIVU)  && (r_prev_sig != FN_DIVU);

   muldiv_seq_unit #(
      .WIDTH (WIDTH)
   ) u_seq (
      .i_clk       (clk),
      .i_reset     (reset),
      .i_start_mul (w_start_mul),
      .i_start_div (w_start_div),
      .i_opa       (dataA),
      .i_opb       (dataB),
      .o_hi        (w_hi),
      .o_lo        (w_lo),
      .o_busy      (busy),
      .o_done      (done),
      .o_dz        (dz)
   );

   assign w_sa  = dataA;
   assign w_sb  = dataB;
   assign w_slt = (w_sa < w_sb);

   always_comb begin
      w_out_next = r_out;
      case (Signal)
         FN_AND:  w_out_next = dataA & dataB;
         FN_OR:   w_out_next = dataA | dataB;
         FN_ADD:  w_out_next = dataA + dataB;
         FN_SUB:  w_out_next = dataA - dataB;
         FN_SLT:  w_out_next = {{(WIDTH-1){1'b0}}, w_slt};
         FN_SRL:  w_out_next = dataA >> dataB[SHW-1:0];
         FN_MFHI: w_out_next = w_hi;
         FN_MFLO: w_out_next = w_lo;
         default: w_out_next = r_out;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_out      <= '0;
         r_prev_sig <= '0;
      end else begin
         r_out      <= w_out_next;
         r_prev_sig <= Signal;
      end
   end

   assign Output = r_out;

endmodule

// File: tb/tb_param_muldiv_alu.sv
// -----------------------------------------------------------------------------
// tb_param_muldiv_alu
// Directed bench for param_muldiv_alu at WIDTH = 32 and WIDTH = 8. Stimulus
// pushes expected values tagged with the cycle at which they must appear; a
// separate monitor pops and compares them on the falling edge.
// -----------------------------------------------------------------------------
module tb_param_muldiv_alu;
   import alu_pkg::*;

   localparam int S_OUT  = 0;
   localparam int S_BUSY = 1;
   localparam int S_DONE = 2;
   localparam int S_DZ   = 3;

   typedef struct {
      int          at;
      int          d;
      int          sel;
      logic [31:0] val;
      string       name;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] a32, b32, o32;
   logic [7:0]  a8, b8, o8;
   logic [5:0]  s32, s8;
   logic        busy32, done32, dz32;
   logic        busy8, done8, dz8;

   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   bit   draining = 1'b0;
   exp_t q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   param_muldiv_alu #(.WIDTH(32)) u_dut32 (
      .clk(clk), .reset(reset), .dataA(a32), .dataB(b32), .Signal(s32),
      .Output(o32), .busy(busy32), .done(done32), .dz(dz32)
   );

   param_muldiv_alu #(.WIDTH(8)) u_dut8 (
      .clk(clk), .reset(reset), .dataA(a8), .dataB(b8), .Signal(s8),
      .Output(o8), .busy(busy8), .done(done8), .dz(dz8)
   );

   function automatic logic [31:0] actual(input int d, input int sel);
      if (d == 32) begin
         case (sel)
            S_OUT:   return o32;
            S_BUSY:  return {31'b0, busy32};
            S_DONE:  return {31'b0, done32};
            default: return {31'b0, dz32};
         endcase
      end else begin
         case (sel)
            S_OUT:   return {24'b0, o8};
            S_BUSY:  return {31'b0, busy8};
            S_DONE:  return {31'b0, done8};
            default: return {31'b0, dz8};
         endcase
      end
   endfunction

   // Monitor: compares every expectation due at the current cycle.
   always @(negedge clk) begin : mon
      logic [31:0] act;
      for (int i = q.size() - 1; i >= 0; i--) begin
         if (q[i].at == cyc || draining) begin
            act = actual(q[i].d, q[i].sel);
            n_tests++;
            if (q[i].at != cyc) begin
               n_fail++;
               $display("FAIL %s (w%0d): check due at cycle %0d never reached", q[i].name, q[i].d, q[i].at);
            end else if (act !== q[i].val) begin
               n_fail++;
               $display("FAIL %s (w%0d): got %h, expected %h", q[i].name, q[i].d, act, q[i].val);
            end
            q.delete(i);
         end
      end
   end

   task automatic expect_at(input int d, input int sel, input int at, input logic [31:0] v, input string nm);
      exp_t e;
      e.at = at; e.d = d; e.sel = sel; e.val = v; e.name = nm;
      q.push_back(e);
   endtask

   task automatic drive(input int d, input logic [5:0] sg, input logic [31:0] a, input logic [31:0] b);
      if (d == 32) begin
         s32 = sg; a32 = a; b32 = b;
      end else begin
         s8 = sg; a8 = a[7:0]; b8 = b[7:0];
      end
   endtask

   // Drive an op for n cycles; if nm is non-empty, Output is checked one clock later.
   task automatic op(input int d, input logic [5:0] sg, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp_v, input string nm, input int n);
      if (nm != "") expect_at(d, S_OUT, cyc + 1, exp_v, nm);
      drive(d, sg, a, b);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset(input int d);
      reset = 1'b1;
      drive(d, 6'd0, 0, 0);
      expect_at(d, S_OUT,  cyc + 1, 0, "rst_out");
      expect_at(d, S_BUSY, cyc + 1, 0, "rst_busy");
      expect_at(d, S_DONE, cyc + 1, 0, "rst_done");
      expect_at(d, S_DZ,   cyc + 1, 0, "rst_dz");
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic run_all(input int d);
      logic [31:0] mask;
      logic [31:0] msb;
      int          c;
      int          rc;
      mask = (d == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
      msb  = (d == 32) ? 32'h8000_0000 : 32'h0000_0080;
      rc   = (d == 32) ? 10 : 4;

      do_reset(d);

      // Single-cycle ops
      op(d, FN_ADD, 7, 5, 12, "add", 1);
      op(d, FN_SUB, 5, 7, mask - 1, "sub", 1);
      op(d, FN_SLT, mask, 1, 1, "slt_neg", 1);
      op(d, FN_SLT, 1, mask, 0, "slt_pos", 1);
      op(d, FN_SRL, msb, d - 1, 1, "srl", 1);
      op(d, FN_OR, 32'h0C, 32'h03, 32'h0F, "or", 1);

      // MULTU all-ones squared, opcode held past done
      c = cyc;
      expect_at(d, S_OUT,  c + 1,     32'h0F, "mul_out_hold");
      expect_at(d, S_BUSY, c + 1,     1, "mul_busy_first");
      expect_at(d, S_BUSY, c + d,     1, "mul_busy_last");
      expect_at(d, S_DONE, c + d,     0, "mul_done_early");
      expect_at(d, S_DONE, c + d + 1, 1, "mul_done");
      expect_at(d, S_BUSY, c + d + 1, 0, "mul_busy_clear");
      expect_at(d, S_DONE, c + d + 2, 0, "mul_done_once");
      expect_at(d, S_BUSY, c + d + 2, 0, "mul_no_restart");
      op(d, FN_MULTU, mask, mask, 0, "", d + 2);
      op(d, FN_MFHI, 0, 0, mask - 1, "mul_hi", 1);
      op(d, FN_MFLO, 0, 0, 1, "mul_lo", 1);

      // DIVU 100 / 7
      c = cyc;
      expect_at(d, S_OUT,  c + 1,     1, "div_out_hold");
      expect_at(d, S_BUSY, c + 1,     1, "div_busy");
      expect_at(d, S_DONE, c + d + 1, 1, "div_done");
      expect_at(d, S_DZ,   c + d + 1, 0, "div_dz");
      op(d, FN_DIVU, 100, 7, 0, "", d + 1);
      op(d, FN_MFLO, 0, 0, 14, "div_lo", 1);
      op(d, FN_MFHI, 0, 0, 2, "div_hi", 1);

      // DIVU 9 / 0
      c = cyc;
      expect_at(d, S_BUSY, c + d,     1, "dz_busy");
      expect_at(d, S_DONE, c + d + 1, 1, "dz_done");
      expect_at(d, S_DZ,   c + d + 1, 1, "dz_set");
      op(d, FN_DIVU, 9, 0, 0, "", d + 1);
      op(d, FN_MFLO, 0, 0, mask, "dz_lo", 1);
      expect_at(d, S_DZ, cyc + 1, 1, "dz_sticky");
      op(d, FN_MFHI, 0, 0, 9, "dz_hi", 1);

      // A new DIVU clears dz at its start
      c = cyc;
      expect_at(d, S_DZ, c + 1, 0, "dz_clear");
      op(d, FN_DIVU, 100, 7, 0, "", d + 1);

      // MULTU 3 * 4 with single-cycle ops and a restart attempt while busy
      c = cyc;
      expect_at(d, S_BUSY, c + d,     1, "mul2_busy");
      expect_at(d, S_DONE, c + d + 1, 1, "mul2_done");
      expect_at(d, S_BUSY, c + d + 1, 0, "mul2_idle");
      expect_at(d, S_DONE, c + d + 2, 0, "mul2_done_once");
      op(d, FN_MULTU, 3, 4, 0, "", 1);
      op(d, FN_AND, 32'hF0, 32'h3C, 32'h30, "and_busy", 1);
      op(d, FN_MFLO, 0, 0, 14, "mflo_old", 1);
      op(d, FN_MULTU, 5, 5, 14, "mul_again_hold", 1);
      op(d, 6'd0, 0, 0, 14, "unk_hold", (c + d + 2) - cyc);
      op(d, FN_MFLO, 0, 0, 12, "mul2_lo", 1);
      op(d, FN_MFHI, 0, 0, 0, "mul2_hi", 1);

      // Reset in the middle of a DIVU
      op(d, FN_ADD, 1, 2, 3, "pre_rst", 1);
      c = cyc;
      expect_at(d, S_BUSY, c + rc,     1, "rst_mid_busy_pre");
      expect_at(d, S_OUT,  c + rc + 1, 0, "rst_mid_out");
      expect_at(d, S_BUSY, c + rc + 1, 0, "rst_mid_busy");
      expect_at(d, S_DONE, c + rc + 1, 0, "rst_mid_done");
      expect_at(d, S_DONE, c + d + 1,  0, "rst_mid_no_done");
      expect_at(d, S_BUSY, c + d + 1,  0, "rst_mid_still_idle");
      op(d, FN_DIVU, 100, 7, 3, "div_rst_hold", 1);
      op(d, 6'd0, 0, 0, 0, "", rc - 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      op(d, FN_MFHI, 0, 0, 0, "rst_mid_hi", 1);
      op(d, FN_MFLO, 0, 0, 0, "rst_mid_lo", 1);
      drive(d, 6'd0, 0, 0);
      while (cyc < c + d + 3) @(negedge clk);
   endtask

   initial begin
      reset = 1'b1;
      drive(32, 6'd0, 0, 0);
      drive(8, 6'd0, 0, 0);
      @(negedge clk);
      run_all(32);
      run_all(8);
      repeat (2) @(negedge clk);
      draining = 1'b1;
      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
